// File: rtl/case_dispatch_scheduler.sv
// case_dispatch_scheduler: round-robin arbiter granting a shared resource for an opcode-class-dependent time.
module case_dispatch_scheduler #(
  parameter int N_REQ  = 4,
  parameter int CODE_W = 3,
  parameter int TMO    = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*CODE_W-1:0] i_code,
  input  logic                    i_done,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [CODE_W-1:0]       o_code,
  output logic                    o_busy,
  output logic                    o_timeout
);
  localparam int PW = $clog2(N_REQ);
  // hold counter must still fit the 4-cycle class-Q length when TMO is tiny
  localparam int CW = $clog2(TMO + 1) > 3 ? $clog2(TMO + 1) : 3;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state;
  logic [PW-1:0] ptr, win, gidx;
  logic [CW-1:0] cnt;
  logic [CODE_W-1:0] win_code;
  logic found, is_w, leave;
  function automatic logic [CW-1:0] hold_len(input logic [CODE_W-1:0] c);
    int v;
    v = int'(c);
    return v == 2 ? CW'(TMO) : (v == 3 || v == 4) ? CW'(2) : (v >= 5 && v <= 7) ? CW'(4) : CW'(1);
  endfunction
  always_comb begin
    found = 1'b0;
    win = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win = PW'(idx);
      end
    end
    win_code = i_code[win*CODE_W +: CODE_W];
    leave = is_w ? (i_done || cnt == CW'(1)) : cnt == CW'(1);
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      ptr <= '0;
      gidx <= '0;
      cnt <= '0;
      is_w <= 1'b0;
      o_gnt <= '0;
      o_code <= '0;
      o_busy <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: if (found) begin
          state <= GRANT;
          o_gnt <= N_REQ'(1) << win;
          o_code <= win_code;
          cnt <= hold_len(win_code);
          is_w <= int'(win_code) == 2;
          gidx <= win;
          o_busy <= 1'b1;
        end
        GRANT: if (leave) begin
          state <= GAP;
          o_gnt <= '0;
          o_timeout <= is_w && !i_done;
          ptr <= gidx == PW'(N_REQ - 1) ? '0 : gidx + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        GAP: begin
          state <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_case_dispatch_scheduler.sv
// tb_case_dispatch_scheduler: directed reset/arbitration checks, then randomized traffic against a grant-level scoreboard.
module tb_case_dispatch_scheduler;
  localparam int N = 4;
  localparam int CW = 3;
  localparam int TMO = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*CW-1:0] code = '0;
  logic done = 1'b0;
  logic [N-1:0] gnt;
  logic [CW-1:0] gcode_o;
  logic busy, tmo_o;
  int checks = 0;
  int errors = 0;
  typedef struct {int idx; int code; int len; bit tmo;} exp_t;
  exp_t q[$];
  bit mon_en = 1'b0;
  logic [N-1:0] pg = '0;
  int m_len = 0;
  logic [CW-1:0] m_code = '0;

  case_dispatch_scheduler #(.N_REQ(N), .CODE_W(CW), .TMO(TMO)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_code(code), .i_done(done),
    .o_gnt(gnt), .o_code(gcode_o), .o_busy(busy), .o_timeout(tmo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // monitor: reconstructs each grant from the outputs and matches it against the next expected grant
  always @(negedge clk) if (mon_en) begin
    chk("onehot0", 32'($onehot0(gnt)), 1);
    if (gnt != 0) chk("busy_in_grant", busy, 1);
    if (gnt != 0 && pg == 0) begin
      m_len = 1;
      m_code = gcode_o;
    end else if (gnt != 0) begin
      chk("gnt_stable", gnt, pg);
      chk("code_stable", gcode_o, m_code);
      m_len++;
    end
    if (gnt == 0 && pg != 0) begin
      chk("busy_in_gap", busy, 1);
      chk("grant_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        exp_t e;
        int gi;
        e = q.pop_front();
        gi = -1;
        for (int k = 0; k < N; k++) if (pg[k]) gi = k;
        chk("grant_idx", gi, e.idx);
        chk("grant_code", m_code, e.code);
        chk("grant_len", m_len, e.len);
        chk("timeout_pulse", tmo_o, e.tmo);
      end
    end else begin
      chk("timeout_quiet", tmo_o, 0);
    end
    pg = gnt;
  end

  initial begin
    int ptr, next_arb, w_c, w_d;
    logic [N-1:0] held;
    ptr = 0;
    next_arb = 0;
    w_c = -1;
    w_d = 0;
    held = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_code", gcode_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tmo_o, 0);
    req = 4'b0100;
    code[2*CW +: CW] = 3'd3;
    @(negedge clk);
    chk("gnt_held_in_rst", gnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", gnt, 4'b0100);
    chk("first_code", gcode_o, 3);
    chk("first_busy", busy, 1);
    req = '0;
    code[2*CW +: CW] = 3'd0;
    @(negedge clk);
    chk("grant_cycle2", gnt, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_gnt", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_timeout", tmo_o, 0);
    chk("abort_code", gcode_o, 0);
    req = 4'b0010;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", gnt, 4'b0010);
    req = 4'b1001;
    @(negedge clk);
    chk("gap_gnt", gnt, 0);
    chk("gap_busy", busy, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("wrap_first", gnt, 4'b1000);
    req = 4'b0001;
    repeat (3) @(negedge clk);
    chk("wrap_second", gnt, 4'b0001);
    req = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [N-1:0] r;
      @(negedge clk);
      for (int k = 0; k < N; k++) r[k] = held[k] | ($urandom_range(3) == 0);
      for (int k = 0; k < N; k++) code[k*CW +: CW] = CW'($urandom);
      if (w_c >= 0 && cyc > w_c && cyc <= w_c + (w_d > TMO ? TMO : w_d)) done = (cyc == w_c + w_d);
      else done = 1'($urandom_range(1));
      req = r;
      held = r;
      if (cyc == next_arb) begin
        if (r != 0) begin
          exp_t e;
          int w, c;
          w = -1;
          for (int i = 0; i < N; i++) if (w < 0 && r[(ptr + i) % N]) w = (ptr + i) % N;
          c = int'(code[w*CW +: CW]);
          e.idx = w;
          e.code = c;
          e.tmo = 1'b0;
          if (c == 2) begin
            w_d = $urandom_range(TMO + 4, 1);
            w_c = cyc;
            e.len = w_d > TMO ? TMO : w_d;
            e.tmo = w_d > TMO;
          end else begin
            e.len = c <= 1 ? 1 : c <= 4 ? 2 : 4;
          end
          q.push_back(e);
          next_arb = cyc + e.len + 2;
          ptr = (w + 1) % N;
          held[w] = 1'b0;
        end else begin
          next_arb = cyc + 1;
        end
      end
    end
    req = '0;
    done = 1'b0;
    repeat (TMO + 10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/case_dispatch_scheduler.md
CASE_DISPATCH_SCHEDULER -- requirements
Module: case_dispatch_scheduler

Interface
REQ-001 Parameter N_REQ SHALL be: default 4; number of requesters, legal range 2..8.
REQ-002 Parameter CODE_W SHALL be: default 3; opcode width per requester.
REQ-003 Parameter TMO SHALL be: default 15; maximum i_done wait in cycles for class-W grants, legal range 1..255.
REQ-004 Port i_clk SHALL be: input, 1 bit; single clock, rising edge.
REQ-005 Port i_rst SHALL be: input, 1 bit; reset, asynchronous and active-low.
REQ-006 Port i_req SHALL be: input, N_REQ bits; per-requester level request, held until granted.
REQ-007 Port i_code SHALL be: input, N_REQ*CODE_W bits; requester k opcode in bits [k*CODE_W +: CODE_W].
REQ-008 Port i_done SHALL be: input, 1 bit; completion strobe from the shared resource.
REQ-009 Port o_gnt SHALL be: output, N_REQ bits; one-hot grant, or all zero.
REQ-010 Port o_code SHALL be: output, CODE_W bits; opcode of the current grantee.
REQ-011 Port o_busy SHALL be: output, 1 bit; high whenever the FSM is not IDLE.
REQ-012 Port o_timeout SHALL be: output, 1 bit; one-cycle pulse on a class-W timeout.

Function
REQ-013 FSM states SHALL be IDLE, GRANT and GAP, all registered.
REQ-014 Opcode classes SHALL decode by value: 0..1 are class S (1 cycle), 2 is class W (wait for i_done), 3..4 are class D (2 cycles), 5..7 are class Q (4 cycles), and values >7 (CODE_W>3) are class S.
REQ-015 In IDLE with any i_req bit set, the winner SHALL be the first set bit searching upward from the pointer ptr with wrap-around; in the next cycle o_gnt is the winner's one-hot, o_code its latched opcode, and the FSM is in GRANT.
REQ-016 Grant latency SHALL be exactly 1 cycle from the edge that samples the request to o_gnt visible.
REQ-017 The opcode SHALL be latched at grant and be insensitive to i_code changes during GRANT.
REQ-018 In GRANT, a hold counter SHALL be loaded with the class length; classes S, D and Q leave GRANT after 1, 2 and 4 cycles respectively.
REQ-019 Class W SHALL leave GRANT the cycle after i_done is sampled high; if i_done is not seen within TMO cycles, o_timeout pulses for 1 cycle coincident with the exit.
REQ-020 i_done SHALL be ignored outside class-W GRANT; i_done on the first GRANT cycle is valid and gives a 1-cycle grant.
REQ-021 GAP SHALL last exactly 1 cycle with o_gnt=0 and o_busy=1, then move to IDLE; ptr is set to (winner+1) mod N_REQ at GAP entry.
REQ-022 Deassertion of the grantee's i_req during GRANT SHALL NOT shorten the grant.
REQ-023 Back-to-back service SHALL be a minimum 3-cycle period for class S (GRANT, GAP, IDLE arbitration).
REQ-024 o_gnt SHALL never have more than one bit set and SHALL be zero outside GRANT.
REQ-025 Counters SHALL be sized ceil(log2(TMO+1)) bits and SHALL NOT wrap.

Reset
REQ-026 Asserting i_rst low SHALL immediately force the FSM to IDLE, ptr=0, o_gnt=0, o_code=0, o_busy=0, o_timeout=0 and counters to 0.
REQ-027 Reset asserted mid-grant SHALL abort the grant with no o_timeout pulse; after release, arbitration restarts from ptr=0.
REQ-028 The first arbitration SHALL occur on the first rising edge with i_rst high.

Verification
REQ-029 Scenario: N_REQ=4, i_req=4'b1111, all codes 0 -> grants in order 0,1,2,3,0, each 1 cycle long, separated by 2 cycles of o_gnt=0.
REQ-030 Scenario: requester 2 only, code 5 -> o_gnt=4'b0100 for exactly 4 cycles and o_code=5; a code change to 0 mid-grant has no effect.
REQ-031 Scenario: code 2 with i_done on the 3rd GRANT cycle -> grant lasts 3 cycles and o_timeout stays 0; with no i_done and TMO=15 -> grant lasts 15 cycles, then a single o_timeout pulse.
REQ-032 Scenario: i_req=4'b1001, ptr=1 -> requester 3 is granted first, then requester 0 (wrap-around).
REQ-033 Scenario: i_rst low on the 2nd cycle of a code-3 grant -> o_gnt=0 immediately; after release with i_req=4'b0010 -> requester 1 is granted 1 cycle later.
REQ-034 Scenario: random requests and codes for 10k cycles -> o_gnt stays one-hot or zero, and every grant length matches its class.
